// File: rtl/instr_encoder.sv
// Instruction-word encoder feeding a 4-deep word FIFO. A word appears on out_valid one cycle after it is accepted.
// in_ready falls only when 4 words are buffered; rejected requests complete the handshake and never stall.

module instr_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  push_dat,
  input  logic          pop,
  output logic [W-1:0]  pop_dat,
  output logic [AW:0]   count
);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && (count != FULL);
  assign do_pop  = pop && (count != '0);
  assign pop_dat = (count != '0) ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: stale entries are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end
endmodule

module instr_encoder (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_fmt,
  input  logic [3:0]  in_op,
  input  logic [3:0]  in_alu,
  input  logic [2:0]  in_br,
  input  logic [3:0]  in_a,
  input  logic [3:0]  in_b,
  input  logic [3:0]  in_d,
  input  logic [31:0] in_const,
  input  logic        in_flag,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        err_pulse,
  output logic [7:0]  err_count,
  output logic [2:0]  level
);
  localparam logic [2:0] FMT_ARITH  = 3'd0;
  localparam logic [2:0] FMT_ARITHC = 3'd1;
  localparam logic [2:0] FMT_CONST  = 3'd2;
  localparam logic [2:0] FMT_BRANCH = 3'd3;
  localparam logic [2:0] FMT_JUMP   = 3'd4;
  localparam logic [2:0] FMT_RAW    = 3'd5;

  logic [31:0] enc_word;
  logic        enc_bad;
  logic        fits_s16;
  logic        fits_c16;
  logic        fits_u27;
  logic        fits_s27;
  logic        accept;
  logic        push;
  logic        reject;
  logic        pop;

  // Range tests: upper bits must be a pure sign extension (or zero for unsigned forms).
  assign fits_s16 = (&in_const[31:15]) || !(|in_const[31:15]);
  assign fits_c16 = !(|in_const[31:16]) || (&in_const[31:15]);
  assign fits_u27 = !(|in_const[31:27]);
  assign fits_s27 = (&in_const[31:26]) || !(|in_const[31:26]);

  always_comb begin
    enc_word = '0;
    enc_bad  = 1'b0;
    case (in_fmt)
      FMT_ARITH:  enc_word = {in_op, in_alu, 12'h000, in_a, in_b, in_d};
      FMT_ARITHC: begin
        enc_word = {in_op, in_alu, in_const[15:0], in_a, in_d};
        enc_bad  = !fits_s16;
      end
      FMT_CONST: begin
        enc_word = {in_op, in_const[15:0], 3'b000, in_flag, 4'h0, in_d};
        enc_bad  = !fits_c16;
      end
      FMT_BRANCH: begin
        enc_word = {in_op, in_const[15:0], in_a, in_b, in_br, in_flag};
        enc_bad  = !fits_s16;
      end
      FMT_JUMP: begin
        enc_word = {in_op, in_const[26:0], in_flag};
        enc_bad  = in_flag ? !fits_s27 : !fits_u27;
      end
      FMT_RAW:    enc_word = in_const;
      default:    enc_bad  = 1'b1;
    endcase
  end

  assign in_ready  = (level < 3'd4);
  assign accept    = in_valid && in_ready;
  assign push      = accept && !enc_bad;
  assign reject    = accept && enc_bad;
  assign out_valid = (level != 3'd0);
  assign pop       = out_valid && out_ready;

  instr_fifo #(.W(32), .DEPTH(4)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_dat (enc_word),
    .pop      (pop),
    .pop_dat  (out_instr),
    .count    (level)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      err_pulse <= 1'b0;
      err_count <= 8'd0;
    end else begin
      err_pulse <= reject;
      if (reject && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
    end
  end
endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed vectors plus a randomized run against a queue-based model.
module tb_instr_encoder;
  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_fmt;
  logic [3:0]  in_op, in_alu, in_a, in_b, in_d;
  logic [2:0]  in_br;
  logic [31:0] in_const;
  logic        in_flag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        err_pulse;
  logic [7:0]  err_count;
  logic [2:0]  level;

  int checks = 0;
  int errors = 0;

  instr_encoder dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_op(in_op), .in_alu(in_alu), .in_br(in_br),
    .in_a(in_a), .in_b(in_b), .in_d(in_d), .in_const(in_const), .in_flag(in_flag),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .err_pulse(err_pulse), .err_count(err_count), .level(level)
  );

  always #5 clk = ~clk;

  // Reference encoder built from field weights and numeric ranges.
  function automatic void model_enc(input longint fmt, input longint op, input longint alu,
                                    input longint br, input longint a, input longint b,
                                    input longint d, input logic [31:0] c, input longint flag,
                                    output logic [31:0] w, output bit rej);
    longint sc, uc, v;
    sc  = longint'($signed(c));
    uc  = longint'(c);
    rej = 1'b0;
    v   = 0;
    case (fmt)
      0: v = op * (2**28) + alu * (2**24) + a * 256 + b * 16 + d;
      1: begin
        rej = (sc < -32768) || (sc > 32767);
        v   = op * (2**28) + alu * (2**24) + (uc % 65536) * 256 + a * 16 + d;
      end
      2: begin
        rej = !((uc < 65536) || (sc < 0 && sc >= -32768));
        v   = op * (2**28) + (uc % 65536) * 4096 + flag * 256 + d;
      end
      3: begin
        rej = (sc < -32768) || (sc > 32767);
        v   = op * (2**28) + (uc % 65536) * 4096 + a * 256 + b * 16 + br * 2 + flag;
      end
      4: begin
        rej = (flag != 0) ? (sc < -(2**26) || sc >= 2**26) : (uc >= 2**27);
        v   = op * (2**28) + (uc % (2**27)) * 2 + flag;
      end
      5: v = uc;
      default: rej = 1'b1;
    endcase
    w = v[31:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; in_fmt = 0; in_op = 0; in_alu = 0; in_br = 0;
    in_a = 0; in_b = 0; in_d = 0; in_const = 0; in_flag = 0;
  endtask

  task automatic drive(input logic [2:0] f, input logic [3:0] op, input logic [3:0] alu,
                       input logic [2:0] br, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] d, input logic [31:0] c, input logic fl);
    in_valid = 1; in_fmt = f; in_op = op; in_alu = alu; in_br = br;
    in_a = a; in_b = b; in_d = d; in_const = c; in_flag = fl;
  endtask

  task automatic do_reset();
    reset = 1; out_ready = 0;
    idle_inputs();
    step();
    reset = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", level); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (out_instr !== 32'h0) begin errors++; $display("FAIL reset_out_instr got %h exp 0", out_instr); end
    checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL reset_err_pulse got %b exp 0", err_pulse); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL reset_err_count got %0d exp 0", err_count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_arithc();
    drive(3'd1, 4'd1, 4'd2, 3'd0, 4'd3, 4'd9, 4'd5, 32'hFFFF_FFFF, 1'b0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arithc_pre_valid got %b exp 0", out_valid); end
    step();
    idle_inputs();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL arithc_valid got %b exp 1", out_valid); end
    checks++; if (out_instr !== 32'h12FFFF35) begin errors++; $display("FAIL arithc_word got %h exp 12ffff35", out_instr); end
    checks++; if (level !== 3'd1) begin errors++; $display("FAIL arithc_level got %0d exp 1", level); end
    checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL arithc_err got %b exp 0", err_pulse); end
    out_ready = 1;
    step();
    out_ready = 0;
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL arithc_drain got %0d exp 0", level); end
  endtask

  task automatic test_branch_jump();
    drive(3'd3, 4'd6, 4'd0, 3'd3, 4'd1, 4'd2, 4'd0, 32'hFFFF_FFFE, 1'b1);
    step();
    drive(3'd4, 4'd9, 4'd0, 3'd0, 4'd0, 4'd0, 4'd0, 32'h0000_0123, 1'b0);
    step();
    idle_inputs();
    checks++; if (level !== 3'd2) begin errors++; $display("FAIL bj_level got %0d exp 2", level); end
    checks++; if (out_instr !== 32'h6FFFE127) begin errors++; $display("FAIL branch_word got %h exp 6fffe127", out_instr); end
    out_ready = 1;
    step();
    checks++; if (out_instr !== 32'h90000246) begin errors++; $display("FAIL jump_word got %h exp 90000246", out_instr); end
    step();
    out_ready = 0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bj_empty got %b exp 0", out_valid); end
  endtask

  task automatic test_reject();
    drive(3'd1, 4'd1, 4'd2, 3'd0, 4'd3, 4'd0, 4'd5, 32'd32768, 1'b0);
    step();
    idle_inputs();
    checks++; if (err_pulse !== 1'b1) begin errors++; $display("FAIL rej_pulse got %b exp 1", err_pulse); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL rej_level got %0d exp 0", level); end
    checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL rej_count got %0d exp 1", err_count); end
    step();
    checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL rej_pulse_end got %b exp 0", err_pulse); end
    drive(3'd7, 4'd0, 4'd0, 3'd0, 4'd0, 4'd0, 4'd0, 32'h0, 1'b0);
    for (int k = 0; k < 253; k++) step();
    checks++; if (err_count !== 8'd254) begin errors++; $display("FAIL rej_count254 got %0d exp 254", err_count); end
    step();
    checks++; if (err_count !== 8'd255) begin errors++; $display("FAIL rej_count255 got %0d exp 255", err_count); end
    step();
    idle_inputs();
    checks++; if (err_count !== 8'd255) begin errors++; $display("FAIL rej_saturate got %0d exp 255", err_count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rej_no_word got %b exp 0", out_valid); end
  endtask

  task automatic test_full();
    logic [31:0] words [5];
    for (int k = 0; k < 5; k++) words[k] = $urandom();
    out_ready = 0;
    for (int k = 0; k < 4; k++) begin
      drive(3'd5, 4'd0, 4'd0, 3'd0, 4'd0, 4'd0, 4'd0, words[k], 1'b0);
      step();
    end
    drive(3'd5, 4'd0, 4'd0, 3'd0, 4'd0, 4'd0, 4'd0, words[4], 1'b0);
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL full_level got %0d exp 4", level); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got %b exp 0", in_ready); end
    step();
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL full_hold got %0d exp 4", level); end
    checks++; if (out_instr !== words[0]) begin errors++; $display("FAIL full_head got %h exp %h", out_instr, words[0]); end
    out_ready = 1;
    step();
    out_ready = 0;
    checks++; if (level !== 3'd3) begin errors++; $display("FAIL full_pop_level got %0d exp 3", level); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_ready_back got %b exp 1", in_ready); end
    step();
    idle_inputs();
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL full_fifth got %0d exp 4", level); end
    out_ready = 1;
    for (int k = 1; k < 5; k++) begin
      checks++; if (out_instr !== words[k]) begin errors++; $display("FAIL full_order idx=%0d got %h exp %h", k, out_instr, words[k]); end
      step();
    end
    out_ready = 0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL full_drained got %b exp 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    out_ready = 0;
    for (int k = 0; k < 2; k++) begin
      drive(3'd5, 4'd0, 4'd0, 3'd0, 4'd0, 4'd0, 4'd0, 32'hA5A5_0000 + k, 1'b0);
      step();
    end
    checks++; if (level !== 3'd2) begin errors++; $display("FAIL mid_level got %0d exp 2", level); end
    reset = 1;
    step();
    reset = 0;
    idle_inputs();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got %b exp 0", out_valid); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL mid_cleared got %0d exp 0", level); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL mid_err_count got %0d exp 0", err_count); end
    out_ready = 1;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_ghost cyc=%0d got %b exp 0", k, out_valid); end
    end
    out_ready = 0;
  endtask

  task automatic test_random();
    logic [31:0] q [$];
    logic [31:0] bnd [12];
    logic [31:0] w;
    bit          rej;
    bit          perr;
    bit          acc;
    int          cnt;
    bnd = '{32'd32767, 32'd32768, 32'hFFFF8000, 32'hFFFF7FFF, 32'd65535, 32'd65536,
            32'h03FF_FFFF, 32'h0400_0000, 32'hFC00_0000, 32'hFBFF_FFFF, 32'h07FF_FFFF, 32'h0800_0000};
    do_reset();
    q = {}; cnt = 0; perr = 0;
    for (int i = 0; i < 1500; i++) begin
      checks++; if (level !== 3'(q.size())) begin errors++; $display("FAIL rnd_level cyc=%0d got %0d exp %0d", i, level, q.size()); end
      checks++; if (out_valid !== (q.size() != 0)) begin errors++; $display("FAIL rnd_valid cyc=%0d got %b", i, out_valid); end
      checks++; if (in_ready !== (q.size() < 4)) begin errors++; $display("FAIL rnd_in_ready cyc=%0d got %b", i, in_ready); end
      checks++; if (err_pulse !== perr) begin errors++; $display("FAIL rnd_err_pulse cyc=%0d got %b exp %b", i, err_pulse, perr); end
      checks++; if (err_count !== 8'(cnt)) begin errors++; $display("FAIL rnd_err_count cyc=%0d got %0d exp %0d", i, err_count, cnt); end
      if (q.size() != 0) begin
        checks++; if (out_instr !== q[0]) begin errors++; $display("FAIL rnd_word cyc=%0d got %h exp %h", i, out_instr, q[0]); end
      end
      in_valid = ($urandom_range(0, 3) != 0);
      in_fmt   = 3'($urandom_range(0, 7));
      in_op    = 4'($urandom()); in_alu = 4'($urandom()); in_br = 3'($urandom());
      in_a     = 4'($urandom()); in_b   = 4'($urandom()); in_d  = 4'($urandom());
      in_flag  = 1'($urandom());
      case ($urandom_range(0, 3))
        0: in_const = bnd[$urandom_range(0, 11)];
        1: in_const = $urandom();
        2: in_const = 32'($urandom_range(0, 40000));
        default: in_const = 32'h0 - 32'($urandom_range(0, 40000));
      endcase
      out_ready = ($urandom_range(0, 2) != 0);
      model_enc(in_fmt, in_op, in_alu, in_br, in_a, in_b, in_d, in_const, in_flag, w, rej);
      acc  = in_valid && (q.size() < 4);
      perr = 0;
      if (out_ready && q.size() != 0) void'(q.pop_front());
      if (acc) begin
        if (rej) begin
          perr = 1;
          if (cnt < 255) cnt++;
        end else begin
          q.push_back(w);
        end
      end
      step();
    end
    idle_inputs();
    out_ready = 0;
  endtask

  initial begin
    reset = 1;
    out_ready = 0;
    idle_inputs();
    test_reset();
    test_arithc();
    test_branch_jump();
    test_reject();
    test_full();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
